// File: rtl/config_loader_pkg.sv
// Shared definitions for the config loader and the config latch array it drives.
// Holds the sequencing states, the default geometry and small helpers.
package config_loader_pkg;

   localparam int NUM_WORDS_DEF = 19;
   localparam int WORD_W_DEF    = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      SETUP  = 3'd2,
      STROBE = 3'd3,
      HOLD   = 3'd4,
      DONE   = 3'd5
   } state_t;

   // A single-word load still needs a one-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_busy(input state_t s);
      return (s == WAIT) || (s == SETUP) || (s == STROBE) || (s == HOLD);
   endfunction

endpackage

// File: rtl/config_loader_onehot_dec.sv
// Binary-to-one-hot decoder for the latch enable bus; all outputs low when en is low.
module onehot_dec
   import config_loader_pkg::*;
#(
   parameter int N     = NUM_WORDS_DEF,
   parameter int IDX_W = idx_width(NUM_WORDS_DEF)
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N-1:0]     onehot
);

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
      assign onehot[gi] = en && (idx == GI_IDX);
   end

endmodule

// File: rtl/config_loader.sv
// Streams NUM_WORDS config words into a level-sensitive latch array, wrapping every
// enable pulse with one cycle of data setup and one cycle of data hold.
module config_loader
   import config_loader_pkg::*;
#(
   parameter int NUM_WORDS = NUM_WORDS_DEF,
   parameter int WORD_W    = WORD_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic                 io_in_valid,
   input  logic [WORD_W-1:0]    io_in_bits,
   output logic                 io_in_ready,
   output logic [WORD_W-1:0]    io_d_in,
   output logic [NUM_WORDS-1:0] io_configs_en,
   output logic                 io_busy,
   output logic                 io_done,
   output logic                 io_err
);

   localparam int               IDX_W    = idx_width(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [WORD_W-1:0]      d_in_q, d_in_d;
   logic [NUM_WORDS-1:0]   en_q, en_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   strobe_next;
   logic [NUM_WORDS-1:0]   dec_out;

   // SETUP always advances to STROBE, so decoding during SETUP lets the enable
   // flops take their strobe value on the same edge the state enters STROBE.
   assign strobe_next = (state_q == SETUP);

   onehot_dec #(
      .N     (NUM_WORDS),
      .IDX_W (IDX_W)
   ) u_onehot_dec (
      .idx    (idx_q),
      .en     (strobe_next),
      .onehot (dec_out)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      d_in_d  = d_in_q;
      err_d   = err_q;

      case (state_q)
         IDLE, DONE: begin
            if (io_start) begin
               state_d = WAIT;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         WAIT: begin
            if (io_in_valid && ready_q) begin
               d_in_d  = io_in_bits;
               state_d = SETUP;
            end
         end
         SETUP:  state_d = STROBE;
         STROBE: state_d = HOLD;
         HOLD: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase

      // A start request mid-load is only flagged; sequencing carries on untouched.
      if (io_start && is_busy(state_q)) begin
         err_d = 1'b1;
      end

      ready_d = (state_d == WAIT);
      busy_d  = is_busy(state_d);
      done_d  = (state_d == DONE);
      en_d    = dec_out;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         d_in_q  <= '0;
         en_q    <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         d_in_q  <= d_in_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign io_in_ready   = ready_q;
   assign io_d_in       = d_in_q;
   assign io_configs_en = en_q;
   assign io_busy       = busy_q;
   assign io_done       = done_q;
   assign io_err        = err_q;

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 19, meaning the number of 32-bit config words per load; the enable vector width.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the config word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port io_start, input, 1 bit: single-cycle request to begin a load of NUM_WORDS words.
REQ-006 SHALL have port io_in_valid, input, 1 bit: upstream word valid.
REQ-007 SHALL have port io_in_bits, input, WORD_W bits: upstream config word.
REQ-008 SHALL have port io_in_ready, output, 1 bit: the loader accepts a word.
REQ-009 SHALL have port io_d_in, output, WORD_W bits: registered data bus to the config latch array.
REQ-010 SHALL have port io_configs_en, output, NUM_WORDS bits: registered one-hot latch enables.
REQ-011 SHALL have port io_busy, output, 1 bit: a load is in progress.
REQ-012 SHALL have port io_done, output, 1 bit: level, set when the last word has been written.
REQ-013 SHALL have port io_err, output, 1 bit: sticky protocol error.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SETUP, STROBE, HOLD, DONE.
REQ-015 IDLE/DONE: io_in_ready=0; io_start=1 -> WAIT with word index idx=0, io_done=0, io_err=0.
REQ-016 WAIT: io_in_ready=1; handshake (io_in_valid & io_in_ready) loads io_in_bits into io_d_in and moves to SETUP.
REQ-017 SETUP: io_configs_en all zero, io_d_in stable; next cycle -> STROBE.
REQ-018 STROBE: io_configs_en[idx]=1, all other bits 0, for exactly one cycle; -> HOLD.
REQ-019 HOLD: io_configs_en all zero, io_d_in unchanged; if idx==NUM_WORDS-1 -> DONE, else idx+1 and -> WAIT.
REQ-020 io_d_in SHALL change only on a WAIT handshake, giving one cycle of setup and one cycle of hold around every enable pulse.
REQ-021 Minimum throughput: one word per 4 cycles; a full load with io_in_valid held high takes 4*NUM_WORDS cycles from the first WAIT cycle to entry into DONE.
REQ-022 io_busy=1 in WAIT, SETUP, STROBE and HOLD; 0 in IDLE and DONE.
REQ-023 io_start while io_busy=1 SHALL be ignored for sequencing and SHALL set io_err=1.
REQ-024 idx SHALL be ceil(log2(NUM_WORDS)) bits and SHALL never exceed NUM_WORDS-1; no wrap-around within a load.
REQ-025 io_in_valid outside WAIT SHALL have no effect; io_in_bits SHALL be sampled only on a handshake.
REQ-026 io_configs_en SHALL come directly from flops so that no combinational glitch reaches the level-sensitive latches.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, idx=0, io_d_in=0, io_configs_en=0, io_in_ready=0, io_busy=0, io_done=0, io_err=0.
REQ-028 Reset during a load SHALL abort it; enables drop to 0 immediately; the partially written latch contents are not restored.

Structure
REQ-029 The FSM state enumeration, NUM_WORDS and WORD_W defaults SHALL live in a shared config package, which the latch array also uses.
REQ-030 The one-hot decoder of idx SHALL be a sub-module named onehot_dec (idx, en -> NUM_WORDS bits).

Verification
REQ-031 Full load: io_start, then 19 words 0x00000000..0x00000012 with valid always high -> each io_configs_en[i] pulses once, in order; io_d_in==i during the pulse; io_done rises 76 cycles after the first WAIT cycle.
REQ-032 Backpressure: valid low for 5 cycles before word 3 -> io_in_ready held 1, no enable pulse, and word 3 is written correctly when valid returns.
REQ-033 Setup/hold: for every pulse, io_d_in is equal in the cycles before, during and after the pulse; no two enable bits are ever high together.
REQ-034 Start while busy: io_start during word 7 -> io_err=1, the load continues unchanged to DONE, and io_err clears on the next io_start from DONE.
REQ-035 Reset mid-load: reset low during the STROBE of word 10 -> all outputs 0 in the same cycle; after release the loader is in IDLE and io_start restarts at idx=0.
REQ-036 Reload: io_start in DONE -> io_done falls next cycle and a second load completes with identical timing.
